data_ram_responder: RTL and testbench

- Memory-side responder for the core's data port. It serves load and store requests from the RV32I core with single-cycle semantics.
- Provides a byte-addressable word RAM with RV32I load/store width and sign handling selected by func3.
- Detects illegal, misaligned and out-of-range accesses and logs the first fault in sticky status registers.
- Keeps saturating load and store counters for bring-up and debug.

---
 rtl/data_ram_responder.sv | 170 +++++++++++++++++
 tb/tb_data_ram_responder.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/data_ram_responder.sv
// Data-port responder for an RV32I core: byte-addressable word RAM with
// func3 width/sign handling, sticky first-fault log and saturating access counters.
module data_ram_responder #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 MemRead,
  input  logic                 MemWrite,
  input  logic [2:0]           func3,
  input  logic [31:0]          addr,
  input  logic [31:0]          w_data,
  output logic [31:0]          r_data,
  input  logic                 fault_clr,
  output logic                 access_fault,
  output logic [31:0]          fault_addr,
  output logic [1:0]           fault_cause,
  output logic [CNT_WIDTH-1:0] load_count,
  output logic [CNT_WIDTH-1:0] store_count
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] CAUSE_NONE    = 2'd0;
  localparam logic [1:0] CAUSE_MISALIGN = 2'd1;
  localparam logic [1:0] CAUSE_RANGE   = 2'd2;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'd3;

  logic [31:0]           r_mem [DEPTH];
  logic                  r_access_fault;
  logic [31:0]           r_fault_addr;
  logic [1:0]            r_fault_cause;
  logic [CNT_WIDTH-1:0]  r_load_count;
  logic [CNT_WIDTH-1:0]  r_store_count;

  logic [ADDR_WIDTH-1:0] w_idx;
  logic [1:0]            w_lane;
  logic                  w_load;
  logic                  w_store;
  logic                  w_illegal;
  logic                  w_misalign;
  logic                  w_range;
  logic [1:0]            w_cause;
  logic                  w_fault;
  logic                  w_load_ok;
  logic                  w_store_ok;
  logic [3:0]            w_be;
  logic [31:0]           w_wdata;
  logic [31:0]           w_word;
  logic [31:0]           w_shift;
  logic [7:0]            w_byte;
  logic [15:0]           w_half;

  assign w_idx   = addr[ADDR_WIDTH+1:2];
  assign w_lane  = addr[1:0];
  assign w_load  = MemRead & ~MemWrite;
  assign w_store = MemWrite;

  // Fault classification; illegal beats misaligned beats out-of-range
  always_comb begin
    w_illegal = 1'b0;
    if (w_store) begin
      w_illegal = (func3 != F3_B) && (func3 != F3_H) && (func3 != F3_W);
    end else begin
      w_illegal = (func3 == 3'b011) || (func3 == 3'b110) || (func3 == 3'b111);
    end
    w_misalign = ((func3[1:0] == 2'b01) && addr[0]) ||
                 ((func3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
    w_range    = |addr[31:ADDR_WIDTH+2];
    if (w_illegal)       w_cause = CAUSE_ILLEGAL;
    else if (w_misalign) w_cause = CAUSE_MISALIGN;
    else if (w_range)    w_cause = CAUSE_RANGE;
    else                 w_cause = CAUSE_NONE;
  end

  assign w_fault    = (w_load | w_store) && (w_cause != CAUSE_NONE);
  assign w_load_ok  = w_load & ~w_fault;
  assign w_store_ok = w_store & ~w_fault;

  // Store lane enables with data replicated across lanes
  always_comb begin
    w_be    = 4'b0000;
    w_wdata = w_data;
    case (func3)
      F3_B: begin
        w_be    = 4'b0001 << w_lane;
        w_wdata = {4{w_data[7:0]}};
      end
      F3_H: begin
        w_be    = addr[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{w_data[15:0]}};
      end
      F3_W:    w_be = 4'b1111;
      default: w_be = 4'b0000;
    endcase
  end

  // Array has no reset so a store coincident with rst still commits
  always_ff @(posedge clk) begin
    if (w_store_ok) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wdata[8*b +: 8];
      end
    end
  end

  assign w_word  = r_mem[w_idx];
  assign w_shift = w_word >> {w_lane, 3'b000};
  assign w_byte  = w_shift[7:0];
  assign w_half  = addr[1] ? w_word[31:16] : w_word[15:0];

  always_comb begin
    r_data = 32'd0;
    if (!rst && w_load_ok) begin
      case (func3)
        F3_B:    r_data = {{24{w_byte[7]}}, w_byte};
        F3_BU:   r_data = {24'd0, w_byte};
        F3_H:    r_data = {{16{w_half[15]}}, w_half};
        F3_HU:   r_data = {16'd0, w_half};
        F3_W:    r_data = w_word;
        default: r_data = 32'd0;
      endcase
    end
  end

  // Sticky first-fault log; a new fault wins over a same-cycle clear
  always_ff @(posedge clk) begin
    if (rst) begin
      r_access_fault <= 1'b0;
      r_fault_addr   <= 32'd0;
      r_fault_cause  <= CAUSE_NONE;
    end else if (w_fault && (!r_access_fault || fault_clr)) begin
      r_access_fault <= 1'b1;
      r_fault_addr   <= addr;
      r_fault_cause  <= w_cause;
    end else if (fault_clr) begin
      r_access_fault <= 1'b0;
      r_fault_addr   <= 32'd0;
      r_fault_cause  <= CAUSE_NONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_load_count  <= '0;
      r_store_count <= '0;
    end else begin
      if (w_load_ok && (r_load_count != '1)) begin
        r_load_count <= r_load_count + CNT_WIDTH'(1);
      end
      if (w_store_ok && (r_store_count != '1)) begin
        r_store_count <= r_store_count + CNT_WIDTH'(1);
      end
    end
  end

  assign access_fault = r_access_fault;
  assign fault_addr   = r_fault_addr;
  assign fault_cause  = r_fault_cause;
  assign load_count   = r_load_count;
  assign store_count  = r_store_count;

endmodule

// File: tb/tb_data_ram_responder.sv
// Self-checking bench for data_ram_responder: directed cases plus random traffic
// against a byte-array reference model.
module tb_data_ram_responder;

  localparam int unsigned AW     = 8;
  localparam int unsigned CW     = 16;
  localparam int unsigned NBYTES = 4 * (1 << AW);
  localparam int          CMAX   = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          MemRead;
  logic          MemWrite;
  logic [2:0]    func3;
  logic [31:0]   addr;
  logic [31:0]   w_data;
  logic [31:0]   r_data;
  logic          fault_clr;
  logic          access_fault;
  logic [31:0]   fault_addr;
  logic [1:0]    fault_cause;
  logic [CW-1:0] load_count;
  logic [CW-1:0] store_count;

  data_ram_responder #(.ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .MemRead(MemRead), .MemWrite(MemWrite),
    .func3(func3), .addr(addr), .w_data(w_data), .r_data(r_data),
    .fault_clr(fault_clr), .access_fault(access_fault),
    .fault_addr(fault_addr), .fault_cause(fault_cause),
    .load_count(load_count), .store_count(store_count)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  // Reference state: memory as a flat byte array, little-endian
  logic [7:0]  mb [NBYTES];
  logic        m_af = 1'b0;
  logic [31:0] m_fa = 32'd0;
  logic [1:0]  m_fc = 2'd0;
  int          m_lc = 0;
  int          m_sc = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [1:0] cause_of(input logic rd, input logic wr,
                                          input logic [2:0] f3, input logic [31:0] a);
    if (!rd && !wr) return 2'd0;
    if (wr ? (f3 > 3'd2) : (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7)) return 2'd3;
    if ((f3[1:0] == 2'd1 && a[0]) || (f3[1:0] == 2'd2 && a[1:0] != 2'd0)) return 2'd1;
    if (a[31:AW+2] != 0) return 2'd2;
    return 2'd0;
  endfunction

  function automatic logic [31:0] load_val(input logic [2:0] f3, input logic [31:0] a);
    int base;
    base = int'(a[AW+1:0]);
    case (f3)
      3'd0:    return 32'($signed(mb[base]));
      3'd4:    return 32'(mb[base]);
      3'd1:    return 32'($signed({mb[base+1], mb[base]}));
      3'd5:    return 32'({mb[base+1], mb[base]});
      3'd2:    return {mb[base+3], mb[base+2], mb[base+1], mb[base]};
      default: return 32'd0;
    endcase
  endfunction

  // One access cycle: check r_data combinationally, clock, update model, check registers
  task automatic acc(input logic rd, input logic wr, input logic [2:0] f3,
                     input logic [31:0] a, input logic [31:0] wd,
                     input logic clr, input logic rs, input bit chk);
    logic [1:0]  c;
    logic [31:0] exp_r;
    int          base;
    MemRead = rd; MemWrite = wr; func3 = f3; addr = a; w_data = wd;
    fault_clr = clr; rst = rs;
    #1;
    c = cause_of(rd, wr, f3, a);
    exp_r = (rs || !rd || wr || c != 2'd0) ? 32'd0 : load_val(f3, a);
    if (chk) check("r_data", r_data, exp_r);
    @(posedge clk);
    base = int'(a[AW+1:0]);
    if (wr && c == 2'd0) begin
      mb[base] = wd[7:0];
      if (f3 != 3'd0) mb[base+1] = wd[15:8];
      if (f3 == 3'd2) begin
        mb[base+2] = wd[23:16];
        mb[base+3] = wd[31:24];
      end
    end
    if (rs) begin
      m_lc = 0; m_sc = 0; m_af = 1'b0; m_fa = 32'd0; m_fc = 2'd0;
    end else begin
      if (rd && !wr && c == 2'd0 && m_lc < CMAX) m_lc++;
      if (wr && c == 2'd0 && m_sc < CMAX) m_sc++;
      if (c != 2'd0 && (!m_af || clr)) begin
        m_af = 1'b1; m_fa = a; m_fc = c;
      end else if (clr) begin
        m_af = 1'b0; m_fa = 32'd0; m_fc = 2'd0;
      end
    end
    #1;
    if (chk) begin
      check("access_fault", 32'(access_fault), 32'(m_af));
      check("fault_addr", fault_addr, m_fa);
      check("fault_cause", 32'(fault_cause), 32'(m_fc));
      check("load_count", 32'(load_count), 32'(m_lc));
      check("store_count", 32'(store_count), 32'(m_sc));
    end
  endtask

  initial begin
    for (int i = 0; i < int'(NBYTES); i++) mb[i] = 8'h00;
    acc(0, 0, 3'd0, 32'h0, 32'h0, 0, 1, 1);

    // Word store/load round trip
    acc(0, 1, 3'd2, 32'h10, 32'h8765_4321, 0, 0, 1);
    acc(1, 0, 3'd2, 32'h10, 32'h0, 0, 0, 1);
    check("tp_lw10", r_data, 32'h8765_4321);

    // Byte store into a zeroed word, then signed/unsigned byte loads
    acc(0, 1, 3'd2, 32'h20, 32'h0, 0, 0, 1);
    acc(0, 1, 3'd0, 32'h23, 32'h1234_56F0, 0, 0, 1);
    acc(1, 0, 3'd2, 32'h20, 32'h0, 0, 0, 1);
    check("tp_lw20", r_data, 32'hF000_0000);
    acc(1, 0, 3'd0, 32'h23, 32'h0, 0, 0, 1);
    check("tp_lb23", r_data, 32'hFFFF_FFF0);
    acc(1, 0, 3'd4, 32'h23, 32'h0, 0, 0, 1);
    check("tp_lbu23", r_data, 32'h0000_00F0);

    // Upper halfword store and halfword loads
    acc(0, 1, 3'd2, 32'h30, 32'h1111_1111, 0, 0, 1);
    acc(0, 1, 3'd1, 32'h32, 32'h0000_8001, 0, 0, 1);
    acc(1, 0, 3'd2, 32'h30, 32'h0, 0, 0, 1);
    check("tp_lw30", r_data, 32'h8001_1111);
    acc(1, 0, 3'd1, 32'h32, 32'h0, 0, 0, 1);
    check("tp_lh32", r_data, 32'hFFFF_8001);
    acc(1, 0, 3'd5, 32'h32, 32'h0, 0, 0, 1);
    check("tp_lhu32", r_data, 32'h0000_8001);

    // Fault log: misaligned, then out-of-range store aliasing word 0, then clear
    acc(0, 1, 3'd2, 32'h0, 32'hA5A5_5A5A, 0, 0, 1);
    acc(1, 0, 3'd2, 32'h6, 32'h0, 0, 0, 1);
    check("tp_mis_cause", 32'(fault_cause), 32'd1);
    check("tp_mis_addr", fault_addr, 32'h6);
    acc(0, 1, 3'd2, 32'h400, 32'hDEAD_BEEF, 0, 0, 1);
    check("tp_oor_keep", 32'(fault_cause), 32'd1);
    acc(1, 0, 3'd2, 32'h0, 32'h0, 0, 0, 1);
    check("tp_oor_nowr", r_data, 32'hA5A5_5A5A);
    acc(0, 0, 3'd0, 32'h0, 32'h0, 1, 0, 1);
    check("tp_clr", 32'(access_fault), 32'd0);

    // Illegal load with a same-cycle clear: capture wins
    acc(1, 0, 3'd3, 32'h0, 32'h0, 1, 0, 1);
    check("tp_ill_cause", 32'(fault_cause), 32'd3);
    acc(1, 1, 3'd3, 32'h8, 32'h0, 0, 0, 1);
    check("tp_ill_sticky", fault_addr, 32'h0);
    acc(0, 0, 3'd0, 32'h0, 32'h0, 1, 0, 1);

    // Fill every word so random loads never hit uninitialised data
    for (int w = 0; w < (1 << AW); w++) acc(0, 1, 3'd2, 32'(w * 4), $urandom, 0, 0, 1);

    for (int i = 0; i < 600; i++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 15) == 0) ? $urandom : {22'd0, 10'($urandom)};
      acc(1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), 3'($urandom_range(0, 7)),
          a, $urandom, ($urandom_range(0, 7) == 0), ($urandom_range(0, 99) == 0), 1);
    end

    // Load counter saturation
    acc(0, 0, 3'd0, 32'h0, 32'h0, 0, 1, 1);
    for (int i = 0; i < 'hFFFE; i++) acc(1, 0, 3'd2, 32'h10, 32'h0, 0, 0, 0);
    check("sat_fffe", 32'(load_count), 32'h0000_FFFE);
    for (int i = 0; i < 3; i++) acc(1, 0, 3'd2, 32'h10, 32'h0, 0, 0, 1);
    check("sat_hold", 32'(load_count), 32'h0000_FFFF);

    // Reset clears counters but not the array; store under reset still lands
    acc(0, 1, 3'd2, 32'h44, 32'hCAFE_F00D, 0, 1, 1);
    check("rst_lc", 32'(load_count), 32'd0);
    check("rst_sc", 32'(store_count), 32'd0);
    acc(1, 0, 3'd2, 32'h44, 32'h0, 0, 0, 1);
    check("rst_store", r_data, 32'hCAFE_F00D);
    acc(1, 0, 3'd2, 32'h10, 32'h0, 0, 0, 1);
    check("rst_keep", r_data, load_val(3'd2, 32'h10));

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
